ex_stall_ctrl: RTL and testbench

Pipeline hazard and multicycle sequencer for the execute stage. It holds a multiply in EX until the Booth multiplier result is valid, and drives the execute stage's `reg_lock` for that time. It detects load-use hazards between EX and ID and inserts one bubble for each. It also aborts a pending multiply stall when an older branch flushes the pipe.

---
 rtl/ex_stall_ctrl.sv | 118 +++++++++++
 tb/tb_ex_stall_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stall_ctrl.sv
// ex_stall_ctrl: execute-stage hazard and multicycle sequencer.
// Holds a Booth multiply in EX until its product is ready, inserts a single
// bubble for each load-use hazard, and abandons a pending multiply when an
// older branch flushes the pipe. All outputs are Mealy and combinational.
module ex_stall_ctrl #(
  parameter int          MULT_LAT  = 4,      // cycles a multiply sits in EX (2..16)
  parameter logic [5:0]  MULT_S_OP = 6'h0e,  // signed multiply alu_ctrl code
  parameter logic [5:0]  MULT_U_OP = 6'h0f   // unsigned multiply alu_ctrl code
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic [5:0] ex_alu_ctrl,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_reg,
  input  logic [4:0] id_regA,
  input  logic [4:0] id_regB,
  input  logic       id_useB,
  input  logic       flush,
  output logic       stall_front,
  output logic       bubble_ex,
  output logic       ex_lock,
  output logic       mem_nop,
  output logic       mult_busy,
  output logic       mult_done
);

  typedef enum logic {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  // The capture cycle and the IDLE lock cycle are not counted by cnt.
  localparam logic [3:0] CNT_INIT = 4'(MULT_LAT - 2);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic is_mult;
  logic load_use;

  assign is_mult = ex_valid &&
                   ((ex_alu_ctrl == MULT_S_OP) || (ex_alu_ctrl == MULT_U_OP));

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign load_use = ex_valid && ex_mem_read && (ex_write_reg != 5'd0) &&
                    ((id_regA == ex_write_reg) ||
                     (id_useB && (id_regB == ex_write_reg)));

  // State and down-counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; priority is flush > multiply > load-use.
  always_comb begin
    // NOTE: every output and next-state signal gets a default before any
    // branch, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_front = 1'b0;
    bubble_ex   = 1'b0;
    ex_lock     = 1'b0;
    mem_nop     = 1'b0;
    mult_busy   = 1'b0;
    mult_done   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          bubble_ex = 1'b1;
        end else if (is_mult) begin
          ex_lock     = 1'b1;
          stall_front = 1'b1;
          mem_nop     = 1'b1;
          cnt_d       = CNT_INIT;
          state_d     = MULT;
        end else if (load_use) begin
          stall_front = 1'b1;
          bubble_ex   = 1'b1;
        end
      end

      MULT: begin
        // Load-use is not evaluated here: ID is frozen behind the multiply.
        if (flush) begin
          // The multiply is younger than the branch and is discarded.
          bubble_ex = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q != 4'd0) begin
          mult_busy   = 1'b1;
          ex_lock     = 1'b1;
          stall_front = 1'b1;
          mem_nop     = 1'b1;
          cnt_d       = cnt_q - 4'd1;
        end else begin
          // Locks released: EX/MEM captures the product this edge.
          mult_busy = 1'b1;
          mult_done = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_stall_ctrl.sv
// Self-checking bench for ex_stall_ctrl. Two instances run side by side on
// the same inputs: the default MULT_LAT=4 and the minimum MULT_LAT=2.
// Output vectors are packed {stall_front, bubble_ex, ex_lock, mem_nop,
// mult_busy, mult_done}.
module tb_ex_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid;
  logic [5:0] ex_alu_ctrl;
  logic       ex_mem_read;
  logic [4:0] ex_write_reg;
  logic [4:0] id_regA;
  logic [4:0] id_regB;
  logic       id_useB;
  logic       flush;

  logic sf_a, bx_a, lk_a, mn_a, mb_a, md_a;
  logic sf_b, bx_b, lk_b, mn_b, mb_b, md_b;

  logic [5:0] obs_a, obs_b;
  assign obs_a = {sf_a, bx_a, lk_a, mn_a, mb_a, md_a};
  assign obs_b = {sf_b, bx_b, lk_b, mn_b, mb_b, md_b};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stall_ctrl #(.MULT_LAT(4)) dut_a (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .id_regA(id_regA), .id_regB(id_regB), .id_useB(id_useB), .flush(flush),
    .stall_front(sf_a), .bubble_ex(bx_a), .ex_lock(lk_a), .mem_nop(mn_a),
    .mult_busy(mb_a), .mult_done(md_a)
  );

  ex_stall_ctrl #(.MULT_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .id_regA(id_regA), .id_regB(id_regB), .id_useB(id_useB), .flush(flush),
    .stall_front(sf_b), .bubble_ex(bx_b), .ex_lock(lk_b), .mem_nop(mn_b),
    .mult_busy(mb_b), .mult_done(md_b)
  );

  // Expected output patterns.
  localparam logic [5:0] E_QUIET = 6'b000000;
  localparam logic [5:0] E_LOCK0 = 6'b101100;  // multiply enters EX
  localparam logic [5:0] E_LOCKB = 6'b101110;  // multiply held, FSM busy
  localparam logic [5:0] E_DONE  = 6'b000011;  // product captured
  localparam logic [5:0] E_LU    = 6'b110000;  // load-use bubble
  localparam logic [5:0] E_FLUSH = 6'b010000;  // flush bubble only

  task automatic set_in(input logic v, input logic [5:0] alu, input logic mr,
                        input logic [4:0] wr, input logic [4:0] ra,
                        input logic [4:0] rb, input logic ub, input logic fl);
    ex_valid     = v;
    ex_alu_ctrl  = alu;
    ex_mem_read  = mr;
    ex_write_reg = wr;
    id_regA      = ra;
    id_regB      = rb;
    id_useB      = ub;
    flush        = fl;
  endtask

  task automatic quiet();
    set_in(1'b0, 6'h00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Move to just after the next rising edge, where new inputs are applied.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: a multiply occupies EX for lat cycles counted
  // from the cycle it enters (k = 0); lock for all but the last.
  task automatic model(input int lat, input bit busy, input int k,
                       output logic [5:0] exp, output bit busy_n,
                       output int k_n);
    bit is_mult, load_use;
    is_mult  = ex_valid && (ex_alu_ctrl == 6'h0e || ex_alu_ctrl == 6'h0f);
    load_use = ex_valid && ex_mem_read && ex_write_reg != 0 &&
               (id_regA == ex_write_reg || (id_useB && id_regB == ex_write_reg));
    exp    = E_QUIET;
    busy_n = busy;
    k_n    = k;
    if (flush) begin
      exp    = E_FLUSH;
      busy_n = 1'b0;
    end else if (busy) begin
      if (k < lat - 1) begin
        exp = E_LOCKB;
        k_n = k + 1;
      end else begin
        exp    = E_DONE;
        busy_n = 1'b0;
      end
    end else if (is_mult) begin
      exp    = E_LOCK0;
      busy_n = 1'b1;
      k_n    = 1;
    end else if (load_use) begin
      exp = E_LU;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet();
    #1;
    total++;
    if (obs_a !== E_QUIET || obs_b !== E_QUIET) begin
      $display("FAIL reset_quiet: got a=%b b=%b want %b", obs_a, obs_b, E_QUIET);
      bad++;
    end
    adv();
    rst = 1'b0;
    // Walk into the MULT cycle with cnt=1 (cycle 2 of a 4-cycle multiply).
    adv();
    set_in(1'b1, 6'h0e, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    adv();
    adv();
    @(negedge clk);
    total++;
    if (obs_a !== E_LOCKB) begin
      $display("FAIL reset_premult: got %b want %b", obs_a, E_LOCKB);
      bad++;
    end
    rst = 1'b1;
    ex_valid = 1'b0;
    #1;
    total++;
    if (mb_a !== 1'b0 || lk_a !== 1'b0) begin
      $display("FAIL reset_midmult: got busy=%b lock=%b want 0 0", mb_a, lk_a);
      bad++;
    end
    adv();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (obs_a !== E_QUIET || obs_b !== E_QUIET) begin
        $display("FAIL reset_after[%0d]: got a=%b b=%b want %b", i, obs_a, obs_b, E_QUIET);
        bad++;
      end
    end
  endtask

  task automatic test_signed_mult();
    logic [5:0] ea [5] = '{E_LOCK0, E_LOCKB, E_LOCKB, E_DONE, E_QUIET};
    logic [5:0] eb [5] = '{E_LOCK0, E_DONE, E_LOCK0, E_DONE, E_QUIET};
    for (int c = 0; c < 5; c++) begin
      adv();
      if (c < 4) set_in(1'b1, 6'h0e, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      else quiet();
      @(negedge clk);
      total++;
      if (obs_a !== ea[c]) begin
        $display("FAIL smul_lat4 c%0d: got %b want %b", c, obs_a, ea[c]);
        bad++;
      end
      total++;
      if (obs_b !== eb[c]) begin
        $display("FAIL smul_lat2 c%0d: got %b want %b", c, obs_b, eb[c]);
        bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ea [9] = '{E_LOCK0, E_LOCKB, E_LOCKB, E_DONE,
                           E_LOCK0, E_LOCKB, E_LOCKB, E_DONE, E_QUIET};
    for (int c = 0; c < 9; c++) begin
      adv();
      if (c < 8) set_in(1'b1, 6'h0f, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      else quiet();
      @(negedge clk);
      total++;
      if (obs_a !== ea[c]) begin
        $display("FAIL b2b_umul c%0d: got %b want %b", c, obs_a, ea[c]);
        bad++;
      end
    end
  endtask

  task automatic test_load_use();
    // lw r5 in EX, add r1,r5,r2 in ID: one bubble.
    adv();
    set_in(1'b1, 6'h00, 1'b1, 5'd5, 5'd5, 5'd2, 1'b1, 1'b0);
    @(negedge clk);
    total++;
    if (obs_a !== E_LU || obs_b !== E_LU) begin
      $display("FAIL lu_basic: got a=%b b=%b want %b", obs_a, obs_b, E_LU);
      bad++;
    end
    // The bubble is now in EX; the dependent add proceeds.
    adv();
    set_in(1'b0, 6'h00, 1'b0, 5'd0, 5'd5, 5'd2, 1'b1, 1'b0);
    @(negedge clk);
    total++;
    if (obs_a !== E_QUIET) begin
      $display("FAIL lu_after_bubble: got %b want %b", obs_a, E_QUIET);
      bad++;
    end
    // Load into r0 never stalls.
    adv();
    set_in(1'b1, 6'h00, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    total++;
    if (obs_a !== E_QUIET) begin
      $display("FAIL lu_r0: got %b want %b", obs_a, E_QUIET);
      bad++;
    end
    // Immediate form: regB match is ignored.
    adv();
    set_in(1'b1, 6'h00, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (obs_a !== E_QUIET) begin
      $display("FAIL lu_imm: got %b want %b", obs_a, E_QUIET);
      bad++;
    end
    // Same registers, register form: regB match stalls.
    adv();
    set_in(1'b1, 6'h00, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    total++;
    if (obs_a !== E_LU) begin
      $display("FAIL lu_regb: got %b want %b", obs_a, E_LU);
      bad++;
    end
    adv();
    quiet();
  endtask

  task automatic test_flush_mult();
    logic [5:0] ea [4] = '{E_LOCK0, E_LOCKB, E_FLUSH, E_QUIET};
    logic [5:0] eb [4] = '{E_LOCK0, E_DONE, E_FLUSH, E_QUIET};
    for (int c = 0; c < 4; c++) begin
      adv();
      if (c < 3) set_in(1'b1, 6'h0e, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, c == 2);
      else quiet();
      @(negedge clk);
      total++;
      if (obs_a !== ea[c]) begin
        $display("FAIL flush_mult_lat4 c%0d: got %b want %b", c, obs_a, ea[c]);
        bad++;
      end
      total++;
      if (obs_b !== eb[c]) begin
        $display("FAIL flush_mult_lat2 c%0d: got %b want %b", c, obs_b, eb[c]);
        bad++;
      end
    end
  endtask

  task automatic test_flush_load_use();
    adv();
    set_in(1'b1, 6'h00, 1'b1, 5'd5, 5'd5, 5'd2, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (obs_a !== E_FLUSH) begin
      $display("FAIL flush_lu: got %b want %b", obs_a, E_FLUSH);
      bad++;
    end
    adv();
    quiet();
  endtask

  task automatic test_random();
    bit         busy_a = 1'b0, busy_b = 1'b0, nb_a, nb_b;
    int         k_a = 0, k_b = 0, nk_a, nk_b;
    logic [5:0] exp_a, exp_b, alu;
    int         sel;
    rst = 1'b1;
    quiet();
    adv();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      adv();
      sel = int'($urandom_range(0, 3));
      alu = (sel == 0) ? 6'h0e : (sel == 1) ? 6'h0f : 6'($urandom);
      set_in(($urandom % 4) != 0, alu, 1'($urandom), 5'($urandom % 4),
             5'($urandom % 4), 5'($urandom % 4), 1'($urandom),
             ($urandom % 8) == 0);
      @(negedge clk);
      model(4, busy_a, k_a, exp_a, nb_a, nk_a);
      model(2, busy_b, k_b, exp_b, nb_b, nk_b);
      total++;
      if (obs_a !== exp_a) begin
        $display("FAIL rand_lat4 c%0d: got %b want %b", c, obs_a, exp_a);
        bad++;
      end
      total++;
      if (obs_b !== exp_b) begin
        $display("FAIL rand_lat2 c%0d: got %b want %b", c, obs_b, exp_b);
        bad++;
      end
      busy_a = nb_a;
      k_a    = nk_a;
      busy_b = nb_b;
      k_b    = nk_b;
    end
    adv();
    quiet();
  endtask

  initial begin
    test_reset();
    test_signed_mult();
    test_back_to_back();
    test_load_use();
    test_flush_mult();
    test_flush_load_use();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
